// File: rtl/watch_pkg.sv
// Shared types and constants for the watch controller counters.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 99;

endpackage

// File: rtl/watch_bin2bcd2.sv
// Combinational binary (0..99) to two-digit BCD conversion.
module watch_bin2bcd2
  import watch_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] bin,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  // Tens digit by threshold compare, so no divider is inferred.
  always_comb begin
    tens = '0;
    for (int t = 1; t <= 9; t++) begin
      if (int'(bin) >= t * 10) begin
        tens = BCD_W'(t);
      end
    end
    ones = BCD_W'(int'(bin) - int'(tens) * 10);
  end

endmodule

// File: rtl/watch_mod_counter.sv
// Dual-range wrap-around counter with run/pause/stop control, adjust, load and BCD outputs.
module watch_mod_counter
  import watch_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned MIN_A = 0,
  parameter int unsigned MAX_A = 23,
  parameter int unsigned MIN_B = 1,
  parameter int unsigned MAX_B = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_resume,
  input  logic             stop,
  input  logic             clr,
  input  logic             tick,
  input  logic             adj,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] value,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             cout,
  output logic             bout,
  output logic             running,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MIN_A_V = WIDTH'(MIN_A);
  localparam logic [WIDTH-1:0] MAX_A_V = WIDTH'(MAX_A);
  localparam logic [WIDTH-1:0] MIN_B_V = WIDTH'(MIN_B);
  localparam logic [WIDTH-1:0] MAX_B_V = WIDTH'(MAX_B);

  state_e           state_q;
  logic             mode_q;
  logic [WIDTH-1:0] min_cur, max_cur, value_d;
  logic             cout_d, bout_d, load_err_d;
  logic [BCD_W-1:0] tens_d, ones_d, rst_tens, rst_ones;

  // Control FSM with registered running flag; stop wins over start_resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      running <= 1'b0;
    end else if (stop) begin
      state_q <= ST_STOPPED;
      running <= 1'b0;
    end else if (start_resume) begin
      if (state_q == ST_RUNNING) begin
        state_q <= ST_PAUSED;
        running <= 1'b0;
      end else begin
        state_q <= ST_RUNNING;
        running <= 1'b1;
      end
    end
  end

  always_comb begin
    min_cur    = mode ? MIN_B_V : MIN_A_V;
    max_cur    = mode ? MAX_B_V : MAX_A_V;
    value_d    = value;
    cout_d     = 1'b0;
    bout_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      value_d = min_cur;
    end else if (load) begin
      if (load_val >= min_cur && load_val <= max_cur) begin
        value_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (mode != mode_q) begin
      // Fold the held value into the newly selected range.
      if (value > max_cur) begin
        value_d = value - max_cur;
      end else if (value < min_cur) begin
        value_d = max_cur;
      end
    end else if (adj) begin
      if (dir) begin
        value_d = (value >= max_cur) ? min_cur : value + 1'b1;
      end else if (value <= min_cur) begin
        value_d = max_cur;
        bout_d  = 1'b1;
      end else begin
        value_d = value - 1'b1;
      end
    end else if (tick && state_q == ST_RUNNING) begin
      if (value >= max_cur) begin
        value_d = min_cur;
        cout_d  = 1'b1;
      end else begin
        value_d = value + 1'b1;
      end
    end
  end

  watch_bin2bcd2 #(.WIDTH(WIDTH)) u_bcd_next (
    .bin  (value_d),
    .tens (tens_d),
    .ones (ones_d)
  );

  watch_bin2bcd2 #(.WIDTH(WIDTH)) u_bcd_rst (
    .bin  (MIN_A_V),
    .tens (rst_tens),
    .ones (rst_ones)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value    <= MIN_A_V;
      tens     <= rst_tens;
      ones     <= rst_ones;
      cout     <= 1'b0;
      bout     <= 1'b0;
      load_err <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      value    <= value_d;
      tens     <= tens_d;
      ones     <= ones_d;
      cout     <= cout_d;
      bout     <= bout_d;
      load_err <= load_err_d;
      mode_q   <= mode;
    end
  end

endmodule

// File: tb/tb_watch_mod_counter.sv
// Randomized and directed bench for watch_mod_counter against an arithmetic reference model.
module tb_watch_mod_counter;

  localparam int MIN_A = 0;
  localparam int MAX_A = 23;
  localparam int MIN_B = 1;
  localparam int MAX_B = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_resume = 1'b0, stop = 1'b0, clr = 1'b0, tick = 1'b0;
  logic       adj = 1'b0, dir = 1'b0, load = 1'b0, mode = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] value;
  logic [3:0] tens, ones;
  logic       cout, bout, running, load_err;

  int n_checks = 0;
  int n_pass = 0;
  int cout_seen = 0;

  // Reference model state: st 0=stopped, 1=running, 2=paused.
  int m_val, m_st, m_mprev, m_cout, m_bout, m_lerr;

  watch_mod_counter #(
    .WIDTH(5), .MIN_A(MIN_A), .MAX_A(MAX_A), .MIN_B(MIN_B), .MAX_B(MAX_B)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_resume (start_resume),
    .stop         (stop),
    .clr          (clr),
    .tick         (tick),
    .adj          (adj),
    .dir          (dir),
    .load         (load),
    .load_val     (load_val),
    .mode         (mode),
    .value        (value),
    .tens         (tens),
    .ones         (ones),
    .cout         (cout),
    .bout         (bout),
    .running      (running),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_val = MIN_A; m_st = 0; m_mprev = 0; m_cout = 0; m_bout = 0; m_lerr = 0;
  endtask

  task automatic model_step();
    int lo, hi, span, lv;
    lo = mode ? MIN_B : MIN_A;
    hi = mode ? MAX_B : MAX_A;
    span = hi - lo + 1;
    lv = int'(load_val);
    m_cout = 0; m_bout = 0; m_lerr = 0;
    if (clr) m_val = lo;
    else if (load) begin
      if (lv >= lo && lv <= hi) m_val = lv;
      else m_lerr = 1;
    end else if (int'(mode) != m_mprev) begin
      if (m_val > hi) m_val = m_val - hi;
      else if (m_val < lo) m_val = hi;
    end else if (adj) begin
      if (!dir && m_val == lo) m_bout = 1;
      m_val = lo + (m_val - lo + (dir ? 1 : span - 1)) % span;
    end else if (tick && m_st == 1) begin
      if (m_val == hi) m_cout = 1;
      m_val = lo + (m_val - lo + 1) % span;
    end
    m_mprev = int'(mode);
    if (stop) m_st = 0;
    else if (start_resume) m_st = (m_st == 1) ? 2 : 1;
  endtask

  task automatic compare_all();
    check("value", 32'(value), 32'(m_val));
    check("tens", 32'(tens), 32'(m_val / 10));
    check("ones", 32'(ones), 32'(m_val % 10));
    check("cout", 32'(cout), 32'(m_cout));
    check("bout", 32'(bout), 32'(m_bout));
    check("load_err", 32'(load_err), 32'(m_lerr));
    check("running", 32'(running), 32'(m_st == 1));
  endtask

  // One clock: inputs already driven; update model, compare, then drop pulses.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (cout === 1'b1) cout_seen++;
    start_resume = 0; stop = 0; clr = 0; tick = 0; adj = 0; load = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_value", 32'(value), 32'(MIN_A));
    check("rst_tens", 32'(tens), 32'd0);
    check("rst_ones", 32'(ones), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_pulses", {29'd0, cout, bout, load_err}, 32'd0);
    reset = 0;

    // Mode 0 full revolution.
    start_resume = 1; cycle();
    cout_seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick = 1; cycle();
      if (i == 22) begin
        check("at23_tens", 32'(tens), 32'd2);
        check("at23_ones", 32'(ones), 32'd3);
      end
    end
    check("wrap_value", 32'(value), 32'd0);
    check("cout_count", 32'(cout_seen), 32'd1);

    // Mode fix cases.
    stop = 1; cycle();
    mode = 1; cycle();
    check("fix0", 32'(value), 32'd12);
    mode = 0; cycle();
    load = 1; load_val = 5'd13; cycle();
    mode = 1; cycle();
    check("fix13", 32'(value), 32'd1);
    mode = 0; cycle();
    load = 1; load_val = 5'd23; cycle();
    mode = 1; cycle();
    check("fix23", 32'(value), 32'd11);
    cycle();
    check("fix_once", 32'(value), 32'd11);

    // Mode 1 counting with wrap 12->1.
    clr = 1; cycle();
    start_resume = 1; cycle();
    cout_seen = 0;
    for (int i = 0; i < 12; i++) begin tick = 1; cycle(); end
    check("b_wrap", 32'(value), 32'd1);
    check("b_cout_count", 32'(cout_seen), 32'd1);

    // Adjust wrap both ways at mode 1 bounds.
    adj = 1; dir = 0; cycle();
    check("adj_dn_val", 32'(value), 32'd12);
    check("adj_dn_bout", 32'(bout), 32'd1);
    adj = 1; dir = 1; cycle();
    check("adj_up_val", 32'(value), 32'd1);
    check("adj_up_cout", 32'(cout), 32'd0);

    // Load checks in mode 0.
    mode = 0; cycle();
    load = 1; load_val = 5'd25; cycle();
    check("load_bad_err", 32'(load_err), 32'd1);
    load = 1; load_val = 5'd7; cycle();
    check("load_ok", {24'd0, tens, ones}, 32'h07);

    // stop beats start_resume; tick while paused does nothing.
    stop = 1; start_resume = 1; cycle();
    check("stop_wins", 32'(running), 32'd0);
    start_resume = 1; cycle();
    start_resume = 1; cycle();
    tick = 1; cycle();
    check("paused_hold", 32'(value), 32'd7);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      start_resume = ($urandom % 10) == 0;
      stop = ($urandom % 25) == 0;
      clr = ($urandom % 40) == 0;
      tick = ($urandom % 2) == 0;
      adj = ($urandom % 8) == 0;
      dir = 1'($urandom);
      load = ($urandom % 15) == 0;
      load_val = 5'($urandom);
      if (!load && ($urandom % 30) == 0) mode = ~mode;
      cycle();
    end

    // Asynchronous reset mid-run.
    mode = 0; cycle();
    start_resume = 1; cycle();
    if (!running) begin start_resume = 1; cycle(); end
    for (int i = 0; i < 5; i++) begin tick = 1; cycle(); end
    #2 reset = 1;
    #1;
    check("async_value", 32'(value), 32'(MIN_A));
    check("async_running", 32'(running), 32'd0);
    check("async_pulses", {29'd0, cout, bout, load_err}, 32'd0);
    #2 reset = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin tick = 1; cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
